// File: rtl/udc_dir_ctrl.sv
// Direction control for the up/down counter: sync + debounce + press-edge per button, then UP/DN FSM.
// Optional ping-pong reversal at count limits under `define UDC_DIR_CTRL_AUTO_REV_EN.
module udc_dir_ctrl #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic [WIDTH-1:0] q,
  output logic             c,
  output logic             dir_pulse,
  output logic             conflict
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic {
    ST_DN = 1'b0,
    ST_UP = 1'b1
  } state_t;

  // Bit 0 carries the up button, bit 1 the down button.
  logic [1:0]    raw;
  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;
  logic          up_ev;
  logic          dn_ev;
  logic          auto_rev;

  state_t state_q;
  logic   dir_pulse_q;
  logic   conflict_q;

  assign raw = {btn_dn, btn_up};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;
  assign up_ev = press[0];
  assign dn_ev = press[1];

`ifdef UDC_DIR_CTRL_AUTO_REV_EN
  // Turn one count early so the counter lands on the limit, never past it.
  assign auto_rev = ((state_q == ST_UP) && (q == {{(WIDTH-1){1'b1}}, 1'b0})) ||
                    ((state_q == ST_DN) && (q == WIDTH'(1)));
`else
  logic unused_q;
  assign unused_q = ^q;
  assign auto_rev = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_UP;
      dir_pulse_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      dir_pulse_q <= 1'b0;
      conflict_q  <= 1'b0;
      if (up_ev && dn_ev) begin
        conflict_q <= 1'b1;
      end else if (dn_ev) begin
        if (state_q == ST_UP) begin
          state_q     <= ST_DN;
          dir_pulse_q <= 1'b1;
        end
      end else if (up_ev) begin
        if (state_q == ST_DN) begin
          state_q     <= ST_UP;
          dir_pulse_q <= 1'b1;
        end
      end else if (auto_rev) begin
        state_q     <= (state_q == ST_UP) ? ST_DN : ST_UP;
        dir_pulse_q <= 1'b1;
      end
    end
  end

  assign c         = (state_q == ST_UP);
  assign dir_pulse = dir_pulse_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_udc_dir_ctrl.sv
// Directed bench for udc_dir_ctrl with DEB_CYCLES = 4; a simple counter model closes the q loop.
module tb_udc_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [3:0] q_m;
  logic       c;
  logic       dir_pulse;
  logic       conflict;

  int total = 0;
  int bad   = 0;

  udc_dir_ctrl #(.WIDTH(4), .DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .q         (q_m),
    .c         (c),
    .dir_pulse (dir_pulse),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) q_m <= 4'd0;
    else      q_m <= c ? q_m + 4'd1 : q_m - 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the buttons for hi edges, releases for lo edges, counting pulses seen.
  task automatic drive(input logic up, input logic dn, input int hi, input int lo,
                       output int np, output int nc);
    np = 0;
    nc = 0;
    btn_up = up;
    btn_dn = dn;
    for (int k = 0; k < hi + lo; k++) begin
      if (k == hi) begin
        btn_up = 1'b0;
        btn_dn = 1'b0;
      end
      tick();
      if (dir_pulse === 1'b1) np++;
      if (conflict === 1'b1) nc++;
      total++;
      if (dir_pulse === 1'b1 && conflict === 1'b1) begin
        bad++;
        $display("FAIL exclusive_pulses: dir_pulse=%b conflict=%b both high", dir_pulse, conflict);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_up = i[0];
      btn_dn = ~i[0];
      tick();
      total++;
      if ({c, dir_pulse, conflict} !== 3'b100) begin
        bad++;
        $display("FAIL reset_hold: c/dir_pulse/conflict=%b%b%b want 100", c, dir_pulse, conflict);
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({c, dir_pulse, conflict} !== 3'b100) begin
        bad++;
        $display("FAIL reset_release: c/dir_pulse/conflict=%b%b%b want 100", c, dir_pulse, conflict);
      end
    end
  endtask

  task automatic test_down_press();
    btn_dn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (c !== (k < 7 ? 1'b1 : 1'b0) || dir_pulse !== (k == 7 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL down_press edge %0d: c=%b dir_pulse=%b want c=%b dir_pulse=%b",
                 k, c, dir_pulse, (k < 7), (k == 7));
      end
    end
    btn_dn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (c !== 1'b0 || dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL down_release: c=%b dir_pulse=%b want c=0 dir_pulse=0", c, dir_pulse);
      end
    end
  endtask

  task automatic test_glitch();
    int np, nc;
    drive(1'b1, 1'b0, 8, 12, np, nc);
    total++;
    if (c !== 1'b1 || np != 1) begin
      bad++;
      $display("FAIL glitch_setup_up: c=%b pulses=%0d want c=1 pulses=1", c, np);
    end
    drive(1'b0, 1'b1, 3, 12, np, nc);
    total++;
    if (c !== 1'b1 || np != 0) begin
      bad++;
      $display("FAIL glitch_3cyc: c=%b pulses=%0d want c=1 pulses=0", c, np);
    end
    drive(1'b0, 1'b1, 4, 12, np, nc);
    total++;
    if (c !== 1'b0 || np != 1) begin
      bad++;
      $display("FAIL glitch_4cyc: c=%b pulses=%0d want c=0 pulses=1", c, np);
    end
  endtask

  task automatic test_redundant();
    int np, nc, np_a, np_b;
    drive(1'b1, 1'b0, 8, 12, np, nc);
    total++;
    if (c !== 1'b1) begin
      bad++;
      $display("FAIL redundant_setup: c=%b want 1", c);
    end
    drive(1'b1, 1'b0, 8, 12, np, nc);
    total++;
    if (c !== 1'b1 || np != 0) begin
      bad++;
      $display("FAIL redundant_up: c=%b pulses=%0d want c=1 pulses=0", c, np);
    end
    drive(1'b0, 1'b1, 8, 12, np_a, nc);
    total++;
    if (c !== 1'b0) begin
      bad++;
      $display("FAIL redundant_dn: c=%b want 0", c);
    end
    drive(1'b1, 1'b0, 8, 12, np_b, nc);
    total++;
    if (c !== 1'b1 || np_a + np_b != 2) begin
      bad++;
      $display("FAIL redundant_back_up: c=%b pulses=%0d want c=1 pulses=2", c, np_a + np_b);
    end
  endtask

  task automatic test_simultaneous();
    int np, nc;
    drive(1'b0, 1'b1, 8, 12, np, nc);
    total++;
    if (c !== 1'b0) begin
      bad++;
      $display("FAIL simul_setup: c=%b want 0", c);
    end
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (c !== 1'b0 || dir_pulse !== 1'b0 || conflict !== (k == 7 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL simultaneous edge %0d: c=%b dir_pulse=%b conflict=%b want 0 0 %b",
                 k, c, dir_pulse, conflict, (k == 7));
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (c !== 1'b0 || dir_pulse !== 1'b0 || conflict !== 1'b0) begin
        bad++;
        $display("FAIL simul_release: c=%b dir_pulse=%b conflict=%b want 0 0 0", c, dir_pulse, conflict);
      end
    end
  endtask

  task automatic test_reset_mid();
    // In DN, with an up press partly debounced, an async reset must force UP at once.
    btn_up = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (c !== 1'b1 || dir_pulse !== 1'b0 || conflict !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: c=%b dir_pulse=%b conflict=%b want 1 0 0", c, dir_pulse, conflict);
    end
    btn_up = 1'b0;
    btn_dn = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (c !== (k < 7 ? 1'b1 : 1'b0) || dir_pulse !== (k == 7 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL post_reset_press edge %0d: c=%b dir_pulse=%b want c=%b dir_pulse=%b",
                 k, c, dir_pulse, (k < 7), (k == 7));
      end
    end
    btn_dn = 1'b0;
  endtask

  task automatic test_auto_rev();
    int t;
    logic [3:0] exp_q;
    logic [3:0] prev_q;
    rst = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    prev_q = 4'd0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      t = k % 30;
      exp_q = (t <= 15) ? 4'(t) : 4'(30 - t);
      total++;
      if (q_m !== exp_q || dir_pulse !== ((t == 15 || t == 0) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL auto_rev edge %0d: q=%h dir_pulse=%b want q=%h dir_pulse=%b",
                 k, q_m, dir_pulse, exp_q, (t == 15 || t == 0));
      end
      total++;
      if ((prev_q == 4'hF && q_m == 4'h0) || (prev_q == 4'h0 && q_m == 4'hF)) begin
        bad++;
        $display("FAIL auto_wrap edge %0d: q went %h -> %h", k, prev_q, q_m);
      end
      prev_q = q_m;
    end
  endtask

  initial begin
`ifdef UDC_DIR_CTRL_AUTO_REV_EN
    test_auto_rev();
`else
    test_reset();
    test_down_press();
    test_glitch();
    test_redundant();
    test_simultaneous();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udc_dir_ctrl.md
Name: udc_dir_ctrl

Overview:
- Upstream control stage for the 4-bit up/down counter; produces the counter's direction input `c` (1 = up, 0 = down).
- Takes two raw, asynchronous push-button inputs, `btn_up` and `btn_dn`. Each is synchronized, debounced and edge-detected, and a direction FSM drives `c` from the results.
- Counter value `q` is fed back so that an optional ping-pong mode can reverse direction at the count limits without wrapping.

Parameters:
- WIDTH, 4, width of the counter value fed back on `q`.
- DEB_CYCLES, 16, number of consecutive identical synchronized samples required before a debounced level changes (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_up  input  1  raw up-request button, asynchronous to `clk`, active-high.
- btn_dn  input  1  raw down-request button, asynchronous to `clk`, active-high.
- q  input  WIDTH  current counter output; used only when AUTO_REV_EN is defined.
- c  output  1  direction to the counter: 1 = count up, 0 = count down.
- dir_pulse  output  1  one-cycle pulse on the cycle `c` takes a new value.
- conflict  output  1  one-cycle pulse when up and down press events occur in the same cycle.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Outputs: c = 1, dir_pulse = 0, conflict = 0.
  - Internal state: synchronizer flops = 0, debounced levels = 0, debounce counters = 0.
  - Effect is immediate. Reset asserted mid-debounce discards the partial count. Reset asserted mid-operation forces direction back to up.
- Synchronizer: two flops per button; only the second-stage value (`sync`) is used downstream.
- Debounce (per button, independent logic):
  - While `sync` != debounced level, the counter increments once per cycle.
  - When `sync` == debounced level, the counter clears to 0.
  - On the DEB_CYCLES-th consecutive differing sample, the debounced level takes the `sync` value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced level.
- Press event: debounced level is 1 and the previous-cycle debounced level is 0 (combinational edge).
  - Release produces no event.
  - A held button produces exactly one event.
- Latency: with a raw button stable high from before edge 1 (edge 1 = first edge that samples it high), `c` and `dir_pulse` update at edge DEB_CYCLES+3.
- Direction FSM, two states: UP (c = 1) and DN (c = 0):
  - UP, down event only → DN; dir_pulse = 1 for one cycle.
  - DN, up event only → UP; dir_pulse = 1 for one cycle.
  - Event that matches the current state (up in UP, down in DN) → no change, no pulse.
  - Up and down events in the same cycle → state held, conflict = 1 for one cycle, dir_pulse = 0.
- `dir_pulse` and `conflict` are registered and are never both high.

Optional Feature:
- Macro: UDC_DIR_CTRL_AUTO_REV_EN.
- When defined (ping-pong mode):
  - In UP with q == 2^WIDTH − 2 (4'hE for WIDTH = 4): go to DN at the next edge with dir_pulse = 1. The counter reaches the maximum (4'hF) and then counts down.
  - In DN with q == 1: go to UP at the next edge with dir_pulse = 1. The counter reaches 0 and then counts up.
  - With this timing the counter never wraps.
  - A button event in the same cycle takes priority over auto-reverse. A conflict in that cycle suppresses auto-reverse for that cycle.
- When not defined: `q` is ignored (port retained, no logic), the counter wraps normally, and direction changes only on button events.

Test Plan (DEB_CYCLES = 4):
- Reset: hold rst = 0 for 3 cycles with buttons toggling → c = 1, dir_pulse = 0 and conflict = 0 throughout. Release → no pulse.
- Down press: btn_dn high from before edge 1 and held 20 cycles → c goes 1→0 at edge 7. dir_pulse is high for exactly one cycle. No further pulses while held or on release.
- Glitch reject: btn_dn high for 3 cycles, then low → c stays 1 and no pulse. Repeat with 4 cycles high → c = 0.
- Redundant press: in UP, press btn_up → c stays 1, no dir_pulse. Then press btn_dn, then btn_up → c returns to 1 with two dir_pulses total.
- Simultaneous: btn_up and btn_dn rise on the same cycle in DN → conflict pulses once at edge 7, c stays 0, dir_pulse = 0.
- With UDC_DIR_CTRL_AUTO_REV_EN, connected to the counter model, free-running from reset:
  - q sequence is 0,1,…,E,F,E,…,1,0,1…
  - dir_pulse when q = F and when q = 0.
  - Never F→0 or 0→F.
